// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I ALU-class decode and single-entry issue register (optional FORWARD_EN operand forwarding)
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
`ifdef FORWARD_EN
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal,
  output logic [31:0] issue_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src1, src2;

  logic [3:0]  dec_op;
  logic [31:0] dec_in1, dec_in2;
  logic        dec_ill;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic        illegal_q, illegal_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;

  logic        capture, handoff;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

`ifdef FORWARD_EN
  // Bypass a pending writeback onto rs1/rs2; x0 is never forwarded.
  always_comb begin
    src1 = rs1_data;
    src2 = rs2_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15])) src1 = fwd_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20])) src2 = fwd_data;
  end
`else
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  // Decode the incoming word into ALU opcode, operands and legality; illegal words yield zero operands.
  always_comb begin
    dec_op  = 4'b0000;
    dec_in1 = 32'd0;
    dec_in2 = 32'd0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op  = {instr[30], funct3};
        dec_in1 = src1;
        dec_in2 = src2;
        if (!((funct7 == F7_ZERO) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          dec_ill = 1'b1;
      end
      OPC_OPIMM: begin
        dec_op  = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
        dec_in1 = src1;
        dec_in2 = {{20{instr[31]}}, instr[31:20]};
        if ((funct3 == 3'b001) || (funct3 == 3'b101))
          dec_in2 = {27'd0, instr[24:20]};
        if ((funct3 == 3'b001) && (funct7 != F7_ZERO))
          dec_ill = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT))
          dec_ill = 1'b1;
      end
      OPC_LUI: begin
        dec_in2 = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec_in1 = pc;
        dec_in2 = {instr[31:12], 12'd0};
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op  = 4'b0000;
      dec_in1 = 32'd0;
      dec_in2 = 32'd0;
    end
  end

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  // Next-state of the output entry and the legal-handoff counter; flush drops the entry and freezes the count.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    issue_cnt_d = issue_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (handoff && !illegal_q) issue_cnt_d = issue_cnt_q + 32'd1;
      if (capture) begin
        out_valid_d = 1'b1;
        alu_op_d    = dec_op;
        in1_d       = dec_in1;
        in2_d       = dec_in2;
        rd_d        = instr[11:7];
        rd_we_d     = !dec_ill;
        illegal_d   = dec_ill;
      end else if (handoff) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output entry register and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= 4'b0000;
      in1_q       <= 32'd0;
      in2_q       <= 32'd0;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      issue_cnt_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;
  assign illegal   = illegal_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed table-driven bench for alu_issue
module tb_alu_issue;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, in1, in2, issue_cnt;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we, illegal;
`ifdef FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
`ifdef FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .in1(in1), .in2(in2), .rd(rd), .rd_we(rd_we), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        chk_ops;
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    instr = i; pc = p; rs1_data = a; rs2_data = b;
  endtask

  initial begin
    logic prev_valid, prev_ill;
    vt[0]  = '{32'hFFF08293, 32'h0, 32'h10,       32'h0,  1'b1, 4'b0000, 32'h10,       32'hFFFFFFFF, 5'd5, 1'b0}; // ADDI x5,x1,-1
    vt[1]  = '{32'h402081B3, 32'h0, 32'h20,       32'h5,  1'b1, 4'b1000, 32'h20,       32'h5,        5'd3, 1'b0}; // SUB
    vt[2]  = '{32'h4030D093, 32'h0, 32'h80,       32'h0,  1'b1, 4'b1101, 32'h80,       32'h3,        5'd1, 1'b0}; // SRAI
    vt[3]  = '{32'h00208233, 32'h0, 32'h11,       32'h22, 1'b1, 4'b0000, 32'h11,       32'h22,       5'd4, 1'b0}; // ADD
    vt[4]  = '{32'h123453B7, 32'h0, 32'h55,       32'h66, 1'b1, 4'b0000, 32'h0,        32'h12345000, 5'd7, 1'b0}; // LUI
    vt[5]  = '{32'hABCDE417, 32'h1000, 32'h55,    32'h66, 1'b1, 4'b0000, 32'h1000,     32'hABCDE000, 5'd8, 1'b0}; // AUIPC
    vt[6]  = '{32'h00000073, 32'h0, 32'h99,       32'h77, 1'b1, 4'b0000, 32'h0,        32'h0,        5'd0, 1'b1}; // ECALL
    vt[7]  = '{32'h0020B4B3, 32'h0, 32'h1,        32'h2,  1'b1, 4'b0011, 32'h1,        32'h2,        5'd9, 1'b0}; // SLTU
    vt[8]  = '{32'h4020C0B3, 32'h0, 32'h1,        32'h2,  1'b0, 4'b0000, 32'h0,        32'h0,        5'd1, 1'b1}; // bad funct7 XOR
    vt[9]  = '{32'h40109093, 32'h0, 32'h1,        32'h2,  1'b0, 4'b0000, 32'h0,        32'h0,        5'd1, 1'b1}; // bad SLLI
    vt[10] = '{32'h01F1D113, 32'h0, 32'hF0000000, 32'h0,  1'b1, 4'b0101, 32'hF0000000, 32'h1F,       5'd2, 1'b0}; // SRLI 31
    vt[11] = '{32'h7FF0F313, 32'h0, 32'hABCD,     32'h0,  1'b1, 4'b0111, 32'hABCD,     32'h7FF,      5'd6, 1'b0}; // ANDI 0x7FF
    vt[12] = '{32'h403150B3, 32'h0, 32'h8,        32'h9,  1'b1, 4'b1101, 32'h8,        32'h9,        5'd1, 1'b0}; // SRA

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
`ifdef FORWARD_EN
    fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0;
`endif
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_in1", in1, 32'd0);
    chk("rst_in2", in2, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_rd_we", {31'd0, rd_we}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_issue_cnt", issue_cnt, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;

    // Table: one entry per cycle, always accepted downstream.
    prev_valid = 1'b0; prev_ill = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      drive(vt[i].instr, vt[i].pc, vt[i].rs1, vt[i].rs2);
      @(posedge clk);
      if (prev_valid && !prev_ill) exp_cnt = exp_cnt + 32'd1;
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].ill});
      chk($sformatf("v%0d_rd_we", i), {31'd0, rd_we}, {31'd0, !vt[i].ill});
      if (vt[i].chk_ops) begin
        chk($sformatf("v%0d_alu_op", i), {28'd0, alu_op}, {28'd0, vt[i].op});
        chk($sformatf("v%0d_in1", i), in1, vt[i].in1);
        chk($sformatf("v%0d_in2", i), in2, vt[i].in2);
      end
      if (!vt[i].ill) chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vt[i].rd});
      chk($sformatf("v%0d_issue_cnt", i), issue_cnt, exp_cnt);
      prev_valid = 1'b1; prev_ill = vt[i].ill;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    if (!prev_ill) exp_cnt = exp_cnt + 32'd1;
    #1;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_issue_cnt", issue_cnt, exp_cnt);

    // Backpressure: entry held stable, in_ready low, then handoff with same-edge capture.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("hold_cap_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h402081B3, 32'h0, 32'h20, 32'h5);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_alu_op", c), {28'd0, alu_op}, 32'd0);
      chk($sformatf("hold%0d_in1", c), in1, 32'h10);
      chk($sformatf("hold%0d_in2", c), in2, 32'hFFFFFFFF);
      chk($sformatf("hold%0d_issue_cnt", c), issue_cnt, exp_cnt);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_cnt = exp_cnt + 32'd1;
    #1;
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_alu_op", {28'd0, alu_op}, 32'b1000);
    chk("b2b_in1", in1, 32'h20);
    chk("b2b_issue_cnt", issue_cnt, exp_cnt);

    // Flush with a held entry and a valid input: entry dropped, nothing captured, count frozen.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_issue_cnt", issue_cnt, exp_cnt);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("post_flush_cnt", issue_cnt, exp_cnt);

    // Counter wrap: preload all-ones, then one legal handoff.
    @(negedge clk);
    dut.issue_cnt_q = 32'hFFFFFFFF;
    in_valid = 1'b1; out_ready = 1'b1;
    drive(32'h00208233, 32'h0, 32'h1, 32'h2);
    @(posedge clk); #1;
    chk("wrap_pre_cnt", issue_cnt, 32'hFFFFFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap_cnt", issue_cnt, 32'h0);
    exp_cnt = 32'h0;

    // Reset while an entry is held, then capture on the first edge after release.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in1", in1, 32'd0);
    chk("mid_rst_rd_we", {31'd0, rd_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h4030D093, 32'h0, 32'h80, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_alu_op", {28'd0, alu_op}, 32'b1101);
    chk("post_rst_in2", in2, 32'h3);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cnt", issue_cnt, 32'd1);

`ifdef FORWARD_EN
    // Forwarding onto rs1 of ADD x4,x1,x2, and x0 never forwarded.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hDEADBEEF;
    drive(32'h00208233, 32'h0, 32'h11, 32'h22);
    @(posedge clk); #1;
    chk("fwd_in1", in1, 32'hDEADBEEF);
    chk("fwd_in2", in2, 32'h22);
    @(negedge clk);
    fwd_rd = 5'd2;
    @(posedge clk); #1;
    chk("fwd2_in1", in1, 32'h11);
    chk("fwd2_in2", in2, 32'hDEADBEEF);
    @(negedge clk);
    fwd_rd = 5'd0;
    drive(32'h00000233, 32'h0, 32'h11, 32'h22);
    @(posedge clk); #1;
    chk("fwd_x0_in1", in1, 32'h11);
    @(negedge clk);
    in_valid = 1'b0; fwd_valid = 1'b0;
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state updates on the rising clk edge.
REQ-002 clk  input  1  clock.
REQ-003 rst  input  1  async active-high reset.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 instr  input  32  RV32I instruction word; pc  input  32  its address.
REQ-007 rs1_data, rs2_data  input  32 each  register-file read data.
REQ-008 flush  input  1  discard held entry and current input.
REQ-009 out_valid  output  1  registered entry valid; out_ready  input  1  ALU stage accepts.
REQ-010 alu_op  output  4  ALU opcode {bit3 variant, funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-011 in1, in2  output  32 each  ALU operands; rd  output  5  destination; rd_we  output  1  writeback enable.
REQ-012 illegal  output  1  entry is not an ALU-class instruction.
REQ-013 issue_cnt  output  32  count of legal entries handed off.

Function
REQ-014 Decode: OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111); any other opcode -> illegal=1, rd_we=0, alu_op=0000, in1=in2=0.
REQ-015 OP: alu_op={instr[30],funct3}, in1=rs1_data, in2=rs2_data; illegal if funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101.
REQ-016 OP-IMM: in1=rs1_data; in2=sign-extended instr[31:20]; alu_op={funct3==101 ? instr[30] : 0, funct3}; shifts: in2={27'b0,instr[24:20]}; illegal if SLLI funct7!=0 or SRLI/SRAI funct7 not 0000000/0100000.
REQ-017 LUI: alu_op=0000, in1=0, in2={instr[31:12],12'b0}; AUIPC: alu_op=0000, in1=pc, same in2.
REQ-018 rd=instr[11:7] and rd_we=1 for legal entries; rd_we=0 when illegal.
REQ-019 Single-entry output register; in_ready = !flush && (!out_valid || out_ready), combinational.
REQ-020 Capture on in_valid && in_ready: decoded fields registered, out_valid=1 next cycle (latency 1).
REQ-021 Handoff on out_valid && out_ready without same-cycle capture -> out_valid=0 next cycle; with capture, new entry replaces old back-to-back (full throughput).
REQ-022 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-023 flush has priority: next cycle out_valid=0, no capture, issue_cnt unchanged that cycle.
REQ-024 issue_cnt increments by 1 per handoff with illegal=0; wraps 0xFFFF_FFFF -> 0; illegal handoffs not counted.

Reset
REQ-025 On rst: out_valid=0, alu_op=0000, in1=in2=0, rd=0, rd_we=0, illegal=0, issue_cnt=0, immediately and asynchronously.
REQ-026 Reset mid-operation discards any held entry; first capture possible on first clk edge after rst deasserts.

Configuration
REQ-027 Macro FORWARD_EN SHALL gate operand forwarding.
REQ-028 With FORWARD_EN: extra inputs fwd_valid (1), fwd_rd (5), fwd_data (32); for OP/OP-IMM, if fwd_valid && fwd_rd!=0 && fwd_rd==instr[19:15], in1=fwd_data; for OP, same rule on instr[24:20] selects in2=fwd_data.
REQ-029 Without FORWARD_EN: fwd_* ports absent; operands come only from rs1_data/rs2_data.

Verification
REQ-030 ADDI x5,x1,-1 (0xFFF08293), rs1_data=0x10 -> next cycle out_valid=1, alu_op=0000, in1=0x10, in2=0xFFFFFFFF, rd=5, rd_we=1.
REQ-031 SUB x3,x1,x2 (0x402081B3) -> alu_op=1000; SRAI x1,x1,3 (0x4030D093) -> alu_op=1101, in2=0x3.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> handoff, issue_cnt+1, next entry captured same edge.
REQ-033 flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no capture, issue_cnt unchanged.
REQ-034 instr=0x00000073 -> illegal=1, rd_we=0, handoff leaves issue_cnt unchanged; preload count 0xFFFFFFFF then legal handoff -> issue_cnt=0.
REQ-035 FORWARD_EN: ADD x4,x1,x2 with fwd_rd=1, fwd_data=0xDEADBEEF -> in1=0xDEADBEEF; fwd_rd=0 -> in1=rs1_data.
